mem_access_unit: RTL and testbench

Initiator-side controller for the 32-word data RAM. It sits between the pipeline's MEM stage and the RAM's word-wide port (write_enable, 5-bit addr, datain, asynchronous dataout). It accepts byte-addressed load/store requests over a valid/ready handshake and performs sign/zero-extended sub-word loads. Sub-word stores use a two-step read-modify-write sequence, and each request returns a response with an error flag.

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and request legality check for the data-RAM access unit.
package mem_access_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  // True for an illegal op (incl. unsigned stores) or a misaligned h/w access.
  function automatic logic op_bad(input logic we, input logic [2:0] op, input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    illegal    = (op == 3'b011) || (op[2:1] == 2'b11) || (we && op[2]);
    misaligned = ((op[1:0] == 2'b01) && lo[0]) || ((op[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide RAM port of the access unit.
interface mem_access_unit_if #(
  parameter int WORD_AW = 5,
  parameter int DATA_W  = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_op;
  logic [31:0]        req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_W-1:0]  resp_rdata;
  logic               resp_err;
  logic               mem_write_enable;
  logic [WORD_AW-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_datain;
  logic [DATA_W-1:0]  mem_dataout;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, resp_ready, mem_dataout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write_enable, mem_addr, mem_datain
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, resp_ready, mem_dataout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_write_enable, mem_addr, mem_datain
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane extract (sign/zero extended) and lane merge for sub-word access.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  always_comb begin
    o_rdata = i_word;
    case (i_op)
      OP_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      OP_BU:   o_rdata = {24'd0, w_byte};
      OP_H:    o_rdata = {{16{w_half[15]}}, w_half};
      OP_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_op[1:0])
      2'b00: begin
        case (i_lane)
          2'd0: o_merged[7:0]   = i_wdata[7:0];
          2'd1: o_merged[15:8]  = i_wdata[7:0];
          2'd2: o_merged[23:16] = i_wdata[7:0];
          2'd3: o_merged[31:24] = i_wdata[7:0];
          default: ;
        endcase
      end
      2'b01: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store controller for the 32-word data RAM;
// sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WORD_AW = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  state_e              r_state;
  state_e              w_next;
  logic                r_we;
  logic [2:0]          r_op;
  logic [WORD_AW+1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_accept;
  logic                w_out_of_range;
  logic                w_req_err;
  logic [DATA_W-1:0]   w_word;
  logic [DATA_W-1:0]   w_extract;
  logic [DATA_W-1:0]   w_merged;

  assign w_accept       = (r_state == S_IDLE) && bus.req_valid;
  assign w_out_of_range = (bus.req_addr >> (WORD_AW + 2)) != 32'd0;
  assign w_req_err      = op_bad(bus.req_we, bus.req_op, bus.req_addr[1:0]) || w_out_of_range;

  // Loads extract straight from the asynchronous RAM output; the merge uses the captured word.
  assign w_word = (r_state == S_READ) ? bus.mem_dataout : r_word;

  mem_lane_align u_lane_align (
    .i_word   (w_word),
    .i_op     (r_op),
    .i_lane   (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .o_rdata  (w_extract),
    .o_merged (w_merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_err)                           w_next = S_RESP;
          else if (bus.req_we && bus.req_op == OP_W) w_next = S_WRITE;
          else                                     w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_op    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_op    <= bus.req_op;
        r_addr  <= bus.req_addr[WORD_AW+1:0];
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
        if (w_req_err) r_rdata <= '0;
      end
      if (r_state == S_READ) begin
        r_word <= bus.mem_dataout;
        if (!r_we) r_rdata <= w_extract;
      end
      if (r_state == S_WRITE) r_rdata <= '0;
    end
  end

  always_comb begin
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_datain       = '0;
    case (r_state)
      S_IDLE:  bus.req_ready = 1'b1;
      S_WRITE: begin
        bus.mem_write_enable = 1'b1;
        bus.mem_datain       = w_merged;
      end
      S_RESP:  bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_addr   = r_addr[WORD_AW+1:2];
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32-word RAM.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b0;
  logic [31:0] ram [32];
  int wr_count = 0;
  int errors = 0;
  int checks = 0;

  mem_access_unit_if #(.WORD_AW(5), .DATA_W(32)) bus ();

  mem_access_unit #(.WORD_AW(5), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_dataout = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= (i >= 1 && i <= 8) ? i : 32'd0;
      wr_count <= 0;
    end else if (bus.mem_write_enable) begin
      ram[bus.mem_addr] <= bus.mem_datain;
      wr_count <= wr_count + 1;
    end
  end

  // Issues one request right after a negedge, waits for the response and consumes it.
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int nwr);
    int wr0;
    wr0 = wr_count;
    bus.req_we = we;
    bus.req_op = op;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) begin
      errors++;
      $display("FAIL resp_timeout: addr=%h got no resp_valid after %0d cycles, want a response", addr, lat);
    end
    checks++;
    rdata = bus.resp_rdata;
    err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    nwr = wr_count - wr0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_op = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    checks++;
    if ({bus.resp_valid, bus.resp_err, bus.mem_write_enable} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got valid/err/we=%b want 000", {bus.resp_valid, bus.resp_err, bus.mem_write_enable});
    end
    checks++;
    if ({bus.resp_rdata, bus.mem_datain, bus.mem_addr} !== 69'd0) begin
      errors++; $display("FAIL reset_data: got rdata=%h datain=%h addr=%h want all 0", bus.resp_rdata, bus.mem_datain, bus.mem_addr);
    end
    checks++;
  endtask

  task automatic test_load_word();
    logic [31:0] rd; logic er; int lat; int nwr;
    do_req(1'b0, 3'b010, 32'h0C, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'h3 || er !== 1'b0) begin errors++; $display("FAIL lw_0c: got rdata=%h err=%b want 00000003 0", rd, er); end
    checks++;
    if (lat != 2 || nwr != 0) begin errors++; $display("FAIL lw_0c_timing: got lat=%0d writes=%0d want 2 0", lat, nwr); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int nwr; int wr0;
    wr0 = wr_count;
    bus.req_we = 1'b1; bus.req_op = 3'b000; bus.req_addr = 32'h04; bus.req_wdata = 32'h55;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (bus.mem_addr !== 5'd1 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_read_state: got addr=%h ready=%b want 01 0", bus.mem_addr, bus.req_ready);
    end
    checks++;
    rst_n = 1'b0;
    @(negedge clk);
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_write_enable} !== 4'b1000 ||
        bus.resp_rdata !== 32'd0 || bus.mem_addr !== 5'd0 || bus.mem_datain !== 32'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got rdy/val/err/we=%b rdata=%h addr=%h datain=%h want 1000 0 0 0",
        {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_write_enable}, bus.resp_rdata, bus.mem_addr, bus.mem_datain);
    end
    checks++;
    rst_n = 1'b1;
    @(negedge clk);
    if (ram[1] !== 32'h1 || wr_count != wr0) begin
      errors++; $display("FAIL mid_reset_no_write: got word1=%h writes=%0d want 00000001 0", ram[1], wr_count - wr0);
    end
    checks++;
    do_req(1'b0, 3'b010, 32'h04, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'h1 || er !== 1'b0) begin errors++; $display("FAIL lw_04_after_reset: got %h err=%b want 00000001 0", rd, er); end
    checks++;
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er; int lat; int nwr;
    do_req(1'b1, 3'b000, 32'h05, 32'h123456AB, rd, er, lat, nwr);
    if (rd !== 32'd0 || er !== 1'b0 || lat != 3 || nwr != 1) begin
      errors++; $display("FAIL sb_05: got rdata=%h err=%b lat=%0d writes=%0d want 0 0 3 1", rd, er, lat, nwr);
    end
    checks++;
    if (ram[1] !== 32'h0000AB01) begin errors++; $display("FAIL sb_05_word1: got %h want 0000ab01", ram[1]); end
    checks++;
    do_req(1'b0, 3'b100, 32'h05, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'h000000AB || lat != 2) begin errors++; $display("FAIL lbu_05: got %h lat=%0d want 000000ab 2", rd, lat); end
    checks++;
    do_req(1'b0, 3'b000, 32'h05, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'hFFFFFFAB || er !== 1'b0) begin errors++; $display("FAIL lb_05: got %h err=%b want ffffffab 0", rd, er); end
    checks++;
  endtask

  task automatic test_half_store();
    logic [31:0] rd; logic er; int lat; int nwr;
    do_req(1'b1, 3'b001, 32'h12, 32'h00008001, rd, er, lat, nwr);
    if (ram[4] !== 32'h80010004 || lat != 3 || nwr != 1) begin
      errors++; $display("FAIL sh_12: got word4=%h lat=%0d writes=%0d want 80010004 3 1", ram[4], lat, nwr);
    end
    checks++;
    do_req(1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_12: got %h want ffff8001", rd); end
    checks++;
    do_req(1'b0, 3'b101, 32'h12, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_12: got %h want 00008001", rd); end
    checks++;
    do_req(1'b0, 3'b101, 32'h10, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'h00000004) begin errors++; $display("FAIL lhu_10: got %h want 00000004", rd); end
    checks++;
  endtask

  task automatic test_word_store();
    logic [31:0] rd; logic er; int lat; int nwr;
    do_req(1'b1, 3'b010, 32'h1C, 32'hDEADBEEF, rd, er, lat, nwr);
    if (ram[7] !== 32'hDEADBEEF || lat != 2 || nwr != 1 || rd !== 32'd0) begin
      errors++; $display("FAIL sw_1c: got word7=%h lat=%0d writes=%0d rdata=%h want deadbeef 2 1 0", ram[7], lat, nwr, rd);
    end
    checks++;
    do_req(1'b0, 3'b000, 32'h1F, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_1f: got %h want ffffffde", rd); end
    checks++;
  endtask

  task automatic test_errors();
    logic        t_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  t_op   [6] = '{3'b010, 3'b010, 3'b011, 3'b100, 3'b001, 3'b111};
    logic [31:0] t_addr [6] = '{32'h06, 32'h80, 32'h00, 32'h08, 32'h03, 32'h04};
    logic [31:0] rd; logic er; int lat; int nwr;
    for (int i = 0; i < 6; i++) begin
      do_req(t_we[i], t_op[i], t_addr[i], 32'hFFFFFFFF, rd, er, lat, nwr);
      if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nwr != 0) begin
        errors++; $display("FAIL err_case%0d: got err=%b rdata=%h lat=%0d writes=%0d want 1 0 1 0", i, er, rd, lat, nwr);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; int nwr; int waited;
    bus.req_we = 1'b0; bus.req_op = 3'b010; bus.req_addr = 32'h08; bus.req_wdata = 32'd0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    waited = 1;
    while (!bus.resp_valid && waited < 16) begin @(negedge clk); waited++; end
    for (int k = 0; k < 5; k++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h2 || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d: got val=%b rdata=%h err=%b ready=%b want 1 00000002 0 0",
          k, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
      end
      checks++;
      if (k < 4) @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++; $display("FAIL after_handshake: got ready=%b valid=%b want 1 0", bus.req_ready, bus.resp_valid);
    end
    checks++;
    do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, nwr);
    if (rd !== 32'h8 || lat != 2) begin errors++; $display("FAIL b2b_lw_20: got %h lat=%0d want 00000008 2", rd, lat); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_reset_mid();
    test_byte_store();
    test_half_store();
    test_word_store();
    test_errors();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
